sync_debounce_reg: RTL
======================

Name: sync_debounce_reg

Overview:
- Parametrised multi-channel input register for the digital-clock button/switch inputs (set, mode, hour+, min+).
- Per channel: synchronises the asynchronous input, debounces it against a tick enable, and registers the clean level as q/qbar.
- Emits one-cycle rise/fall pulses to the time-set and mode control logic.
- Successor to the single-bit D flip-flop: adds width, sync depth, reset, enable gating and edge detection.

Parameters:
- WIDTH, 4, number of independent input channels.
- SYNC_STAGES, 2, flip-flop stages in each synchroniser chain; must be >= 2.
- DEBOUNCE_CYCLES, 16, consecutive en ticks of stable mismatch required to commit a new level; must be >= 1.
- REPEAT_DELAY, 500, en ticks from press commit to the first auto-repeat pulse (HOLD_REPEAT_EN only).
- REPEAT_RATE, 100, en ticks between subsequent auto-repeat pulses (HOLD_REPEAT_EN only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  debounce tick enable (e.g. 1 kHz strobe, one clk wide); tie high for per-clock debounce.
- din  in  WIDTH  raw asynchronous inputs, active high.
- q  out  WIDTH  debounced level, registered.
- qbar  out  WIDTH  registered exact complement of q.
- rise  out  WIDTH  one-clk pulse on 0->1 commit (plus repeats when enabled).
- fall  out  WIDTH  one-clk pulse on 1->0 commit.

Behaviour:
- Reset (rst_n low, async, any time): sync chains, counters and q are 0; qbar is all ones; rise and fall are 0. All activity restarts from zero after release.
- Sync chain: din[i] is shifted through SYNC_STAGES flops every clk, independent of en. s[i] is the last stage.
- Per-channel debounce counter, width $clog2(DEBOUNCE_CYCLES+1), evaluated each clk edge:
  - s==q: counter clears, regardless of en.
  - s!=q, en=0: counter holds.
  - s!=q, en=1, counter<DEBOUNCE_CYCLES-1: counter increments.
  - s!=q, en=1, counter==DEBOUNCE_CYCLES-1: commit q<=s, counter clears.
- Glitch rejection: any return of s to q before commit discards the count.
- qbar: updates on the same edge as q. qbar==~q holds in every cycle, with no one-cycle lag.
- rise/fall: registered and asserted for exactly one clk cycle, coincident with the first cycle q shows the new value. Otherwise 0.
- Latency with en=1 and din held: q changes after exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges.
- Channels are fully independent. Simultaneous commits on several channels produce simultaneous pulses.
- Counters never wrap; they saturate at commit by clearing.

Optional Feature:
- Macro: HOLD_REPEAT_EN.
- Defined: a per-channel repeat counter runs while q[i]=1, counting en ticks.
  - The first extra rise[i] pulse fires REPEAT_DELAY ticks after the commit; further pulses fire every REPEAT_RATE ticks.
  - Each pulse is one clk wide, on the edge where the terminal tick is counted.
  - The counter clears while q[i]=0 and on reset. fall is unaffected.
- Not defined: no repeat logic is generated. rise fires only on commit, and REPEAT_* parameters are ignored.

Test Plan:
- Reset: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, en=1; hold rst_n=0 with din=4'hF -> q=4'h0, qbar=4'hF, rise=fall=4'h0 throughout.
- Press: din[0] 0->1 and held -> q[0]=1 and qbar[0]=0 after exactly 6 edges; rise[0]=1 for one cycle only. Release -> q[0]=0 after 6 edges; fall[0] pulses once.
- Glitch: din[1] high for 3 clk then low -> q[1] stays 0; rise[1] and fall[1] stay 0.
- en gating: en pulses once per 10 clk; din[2] held high -> q[2] commits on the 4th en tick after s[2] goes high, never earlier. Dropping din[2] after the 2nd tick -> no commit.
- Simultaneous and reset mid-count: din 4'h0->4'hF -> rise=4'hF in one cycle. Then din->4'h0, assert rst_n after 3 count edges -> all outputs at reset values. After release with din=4'h0 -> no pulses.
- HOLD_REPEAT_EN, REPEAT_DELAY=8, REPEAT_RATE=3, en=1: hold din[3] high -> rise[3] at commit, then at commit+8, +11, +14 ticks. Release -> repeats stop and fall[3] pulses once.

Source files
------------

// File: rtl/sync_debounce_reg.sv
// Multi-channel button/switch input register: synchroniser, en-tick debouncer, q/qbar and edge pulses.
// Define HOLD_REPEAT_EN to add auto-repeat rise pulses while a channel is held high.
module sync_debounce_reg #(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 500,
   parameter int REPEAT_RATE     = 100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("sync_debounce_reg: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
   end

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] s;
   logic [CNT_W-1:0] cnt_q  [WIDTH];
   logic [CNT_W-1:0] cnt_d  [WIDTH];
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] qbar_q, rise_q, fall_q;
   logic [WIDTH-1:0] rpt_pulse;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= din;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Any return of s to the committed level discards the partial count.
   always_comb begin
      q_d = q_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s[i] == q_q[i]) begin
            cnt_d[i] = '0;
         end else if (en) begin
            if (cnt_q[i] == CNT_LAST) begin
               q_d[i]   = s[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // qbar and the pulses derive from q_d so they line up with q on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q    <= '0;
         qbar_q <= '1;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         q_q    <= q_d;
         qbar_q <= ~q_d;
         rise_q <= (q_d & ~q_q) | rpt_pulse;
         fall_q <= ~q_d & q_q;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

`ifdef HOLD_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

   if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rpt
      $error("sync_debounce_reg: REPEAT_DELAY and REPEAT_RATE must be >= 1");
   end

   logic [RPT_W-1:0] rpt_cnt_q [WIDTH];
   logic [RPT_W-1:0] rpt_cnt_d [WIDTH];
   logic [WIDTH-1:0] rpt_phase_q, rpt_phase_d;

   // phase 0 waits out the initial delay, phase 1 repeats at the steady rate.
   always_comb begin
      rpt_pulse   = '0;
      rpt_phase_d = rpt_phase_q;
      for (int i = 0; i < WIDTH; i++) begin
         rpt_cnt_d[i] = rpt_cnt_q[i];
         if (!q_q[i]) begin
            rpt_cnt_d[i]   = '0;
            rpt_phase_d[i] = 1'b0;
         end else if (en) begin
            if (rpt_cnt_q[i] == (rpt_phase_q[i] ? RATE_LAST : DELAY_LAST)) begin
               rpt_pulse[i]   = q_d[i];
               rpt_cnt_d[i]   = '0;
               rpt_phase_d[i] = 1'b1;
            end else begin
               rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_phase_q <= '0;
         for (int i = 0; i < WIDTH; i++) rpt_cnt_q[i] <= '0;
      end else begin
         rpt_phase_q <= rpt_phase_d;
         for (int i = 0; i < WIDTH; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
   end
`else
   if (REPEAT_DELAY < 0 || REPEAT_RATE < 0) begin : g_bad_rpt
      $error("sync_debounce_reg: REPEAT_DELAY and REPEAT_RATE must not be negative");
   end

   assign rpt_pulse = '0;
`endif

   assign q    = q_q;
   assign qbar = qbar_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule
